// File: rtl/warrants_code_table.sv
// Dual-port warrant-code table: host/sweep share port A, lookups read port B
// with two-cycle latency and write-first bypass against same-cycle host writes.
module warrants_code_table #(
  parameter int unsigned           DATA_WIDTH = 48,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic                  host_clr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [ADDR_WIDTH-1:0] lkp_addr,
  output logic                  lkp_rsp_valid,
  output logic [DATA_WIDTH-1:0] lkp_rsp_data,
  output logic [31:0]           lkp_count
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  wr_acc;
  logic                  lkp_acc;
  logic                  bypass;
  logic                  l1_valid;
  logic [DATA_WIDTH-1:0] l1_data;

  assign idle      = (state == ST_IDLE);
  assign wr_acc    = idle && !host_clr && host_req && host_wr;
  assign init_done = (state != ST_INIT);
  assign lkp_ready = init_done;
  assign lkp_acc   = lkp_valid && lkp_ready;
  assign host_ack  = (state == ST_ACK);
  assign bypass    = wr_acc && (host_addr == lkp_addr);

  // Port A: the sweep owns it in INIT, the host owns it otherwise.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_addr] <= INIT_VALUE;
    end else if (wr_acc) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
      rd_addr    <= '0;
      host_rdata <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
          if (&sweep_addr) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (host_clr) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
          end else if (host_req) begin
            rd_addr <= host_addr;
            state   <= host_wr ? ST_ACK : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          host_rdata <= mem[rd_addr];
          state      <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Port B: stage 1 captures the RAM (or bypassed host data) at acceptance,
  // so later host writes cannot leak into an in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l1_valid      <= 1'b0;
      l1_data       <= '0;
      lkp_rsp_valid <= 1'b0;
      lkp_rsp_data  <= '0;
      lkp_count     <= '0;
    end else begin
      l1_valid <= lkp_acc;
      if (lkp_acc) begin
        l1_data   <= bypass ? host_wdata : mem[lkp_addr];
        lkp_count <= lkp_count + 32'd1;
      end
      lkp_rsp_valid <= l1_valid;
      if (l1_valid) begin
        lkp_rsp_data <= l1_data;
      end
    end
  end
endmodule

// File: tb/tb_warrants_code_table.sv
// Randomised scoreboard bench for warrants_code_table (16 entries, init 0xAAAA):
// the driver pushes expected responses, a negedge monitor pops and compares.
module tb_warrants_code_table;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 48;
  localparam int unsigned N  = 16;
  localparam logic [DW-1:0] IV = 48'hAAAA;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic          host_req, host_wr, host_clr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack;
  logic          lkp_valid, lkp_ready;
  logic [AW-1:0] lkp_addr;
  logic          lkp_rsp_valid;
  logic [DW-1:0] lkp_rsp_data;
  logic [31:0]   lkp_count;

  warrants_code_table #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .host_req(host_req), .host_wr(host_wr), .host_clr(host_clr),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
    .lkp_addr(lkp_addr), .lkp_rsp_valid(lkp_rsp_valid),
    .lkp_rsp_data(lkp_rsp_data), .lkp_count(lkp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        hq[$];
  exp_t        lq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          sweep_left = 0;
  int          host_left = 0;
  int unsigned lcount = 0;
  logic [DW-1:0] model [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d: %s", name, cyc, what);
  endtask

  // Monitor: pops one expectation per presented response, flags overdue ones.
  always @(negedge clk) begin
    exp_t e;
    if (host_ack) begin
      if (hq.size() == 0) flag("host_ack", "ack seen, none expected");
      else begin
        e = hq.pop_front();
        check("host_ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) check("host_rdata", 64'(host_rdata), 64'(e.data));
      end
    end
    while (hq.size() > 0 && hq[0].cyc < cyc) begin
      flag("host_ack", "expected ack never seen");
      hq.delete(0);
    end
    if (lkp_rsp_valid) begin
      if (lq.size() == 0) flag("lkp_rsp", "response seen, none expected");
      else begin
        e = lq.pop_front();
        check("lkp_rsp_cycle", 64'(cyc), 64'(e.cyc));
        check("lkp_rsp_data", 64'(lkp_rsp_data), 64'(e.data));
      end
    end
    while (lq.size() > 0 && lq[0].cyc < cyc) begin
      flag("lkp_rsp", "expected response never seen");
      lq.delete(0);
    end
  end

  task automatic idle_in();
    host_req = 0; host_wr = 0; host_clr = 0; host_addr = '0; host_wdata = '0;
    lkp_valid = 0; lkp_addr = '0;
  endtask

  task automatic fill_model();
    for (int i = 0; i < N; i++) model[i] = IV;
  endtask

  // One cycle: apply the table's rules to the current inputs, then advance.
  task automatic tick();
    bit   host_free, wr_acc, rd_acc, clr_acc, lk_acc;
    exp_t e;
    check("init_done", 64'(init_done), 64'(sweep_left == 0));
    check("lkp_ready", 64'(lkp_ready), 64'(sweep_left == 0));
    host_free = (sweep_left == 0) && (host_left == 0);
    clr_acc = host_free && host_clr;
    wr_acc  = host_free && !host_clr && host_req && host_wr;
    rd_acc  = host_free && !host_clr && host_req && !host_wr;
    lk_acc  = lkp_valid && (sweep_left == 0);
    if (sweep_left > 0) sweep_left--;
    if (host_left > 0) host_left--;
    if (wr_acc) begin
      model[host_addr] = host_wdata;
      e.cyc = cyc + 1; e.rd = 0; e.data = '0;
      hq.push_back(e);
      host_left = 1;
    end
    if (rd_acc) begin
      e.cyc = cyc + 2; e.rd = 1; e.data = model[host_addr];
      hq.push_back(e);
      host_left = 2;
    end
    if (lk_acc) begin
      e.cyc = cyc + 2; e.rd = 0; e.data = model[lkp_addr];
      lq.push_back(e);
      lcount++;
    end
    if (clr_acc) begin
      fill_model();
      sweep_left = N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_done"}, 64'(init_done), 64'd0);
    check({tag, "_host_ack"}, 64'(host_ack), 64'd0);
    check({tag, "_host_rdata"}, 64'(host_rdata), 64'd0);
    check({tag, "_lkp_rsp_valid"}, 64'(lkp_rsp_valid), 64'd0);
    check({tag, "_lkp_rsp_data"}, 64'(lkp_rsp_data), 64'd0);
    check({tag, "_lkp_count"}, 64'(lkp_count), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #1;
    check_reset_outputs(tag);
    hq.delete(); lq.delete();
    lcount = 0; host_left = 0; sweep_left = N;
    fill_model();
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic host_op(input bit wr, input int addr, input logic [DW-1:0] d);
    host_req = 1; host_wr = wr; host_addr = AW'(addr); host_wdata = d;
    tick();
    idle_in();
  endtask

  logic [63:0] r;

  initial begin
    idle_in();
    fill_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 0;
    sweep_left = N;
    run(N);

    for (int i = 0; i < N; i++) begin
      lkp_valid = 1; lkp_addr = AW'(i);
      tick();
    end
    idle_in();
    run(3);
    check("stream_lkp_count", 64'(lkp_count), 64'd16);

    lkp_valid = 1; lkp_addr = 0;  tick();
    lkp_addr = AW'(15);           tick();
    idle_in();
    run(3);

    host_op(1, 3, 48'h0000_1234_5678);
    tick();
    host_op(0, 3, '0);
    run(3);

    host_req = 1; host_wr = 1; host_addr = 7; host_wdata = 48'hBEEF;
    lkp_valid = 1; lkp_addr = 7;
    tick();
    host_wdata = 48'hCAFE;
    tick();
    tick();
    idle_in();
    run(4);

    host_op(1, 0, 48'h1111);
    tick();
    host_op(1, 15, 48'h2222);
    tick();
    host_clr = 1;
    lkp_valid = 1; lkp_addr = 15;
    tick();
    host_clr = 0; lkp_valid = 0;
    host_req = 1; host_wr = 0; host_addr = 15;
    run(N);
    idle_in();
    tick();
    for (int i = 0; i < N; i++) begin
      lkp_valid = 1; lkp_addr = AW'(i);
      tick();
    end
    idle_in();
    host_op(0, 0, '0);
    run(2);
    host_op(0, 15, '0);
    run(3);
    check("lkp_count_model", 64'(lkp_count), 64'(lcount));

    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      host_req   = ($urandom_range(0, 2) == 0);
      host_wr    = $urandom_range(0, 1) == 1;
      host_clr   = ($urandom_range(0, 63) == 0);
      host_addr  = AW'($urandom_range(0, N - 1));
      host_wdata = r[DW-1:0];
      lkp_valid  = $urandom_range(0, 1) == 1;
      lkp_addr   = ($urandom_range(0, 3) == 0) ? host_addr : AW'($urandom_range(0, N - 1));
      tick();
    end
    idle_in();
    run(20);
    check("lkp_count_random", 64'(lkp_count), 64'(lcount));

    host_clr = 1;
    tick();
    idle_in();
    run(5);
    do_reset("mid_sweep");
    run(N);
    host_op(1, 9, 48'h5555_0000_1234);
    tick();
    host_op(0, 9, '0);
    run(2);
    host_op(0, 9, '0);
    lkp_valid = 1; lkp_addr = 9;
    do_reset("mid_read");
    run(N);
    check("post_reset_lkp_count", 64'(lkp_count), 64'd0);
    lkp_valid = 1; lkp_addr = 9;
    tick();
    idle_in();
    run(4);

    check("host_queue_drained", 64'(hq.size()), 64'd0);
    check("lkp_queue_drained", 64'(lq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: simulation time limit reached", cyc);
    $fatal(1);
  end
endmodule
